// File: rtl/serial_adder_nb.sv
// Digit-serial ripple adder: WIDTH-bit operands, DIGIT bits per clock, start/busy/done handshake.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_nb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int unsigned N        = WIDTH / DIG_SAFE;
  localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1;

  generate
    if ((DIGIT < 1) || ((WIDTH % DIG_SAFE) != 0)) begin : g_bad_params
      $error("serial_adder_nb: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0]       a_dig;
  logic [DIGIT-1:0]       b_dig;
  logic [DIGIT-1:0]       s_dig;
  logic [DIGIT:0]         c;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  assign b_dig = b_sr[DIGIT-1:0] ^ {DIGIT{sub_q}};
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_dig = b_sr[DIGIT-1:0];
`endif

  assign a_dig = a_sr[DIGIT-1:0];
  assign c[0]  = carry;

  // DIGIT-long ripple of 1-bit full-adder cells
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_dig[i] = a_dig[i] ^ b_dig[i] ^ c[i];
    assign c[i+1]   = (a_dig[i] & b_dig[i]) | (c[i] & (a_dig[i] ^ b_dig[i]));
  end

  // New digit enters at the MSB end so the final shift leaves the result aligned
  assign acc_cat  = {s_dig, acc};
  assign acc_next = WIDTH'(acc_cat >> DIGIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q <= sub;
            carry <= sub ? 1'b1 : cin;
`else
            carry <= cin;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          acc   <= acc_next;
          carry <= c[DIGIT];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sum   <= acc_next;
            cout  <= c[DIGIT];
            ovf   <= c[DIGIT] ^ c[DIGIT-1];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_nb.sv
// Bench for serial_adder_nb: directed handshake cases on 8/2, random vectors on 8/2, 8/1 and 16/4.
module tb_serial_adder_nb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st0, st1, st2;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        cin, sub;

  logic        busy0, done0, cout0, ovf0;
  logic [7:0]  sum0;
  logic        busy1, done1, cout1, ovf1;
  logic [7:0]  sum1;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] sum2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_nb #(.WIDTH(8), .DIGIT(2)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .a(a8), .b(b8), .cin(cin), .sub(sub),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

  serial_adder_nb #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .a(a8), .b(b8), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  serial_adder_nb #(.WIDTH(16), .DIGIT(4)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .a(a16), .b(b16), .cin(cin), .sub(sub),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-word arithmetic reference: subtract is a + ~b + 1, overflow from operand/result signs
  function automatic void model(input int w, input logic [15:0] x, input logic [15:0] y,
                                input logic c, input logic s,
                                output logic [15:0] sm, output logic co, output logic ov);
    logic [31:0] mask, xx, yy, full;
    logic        se;
`ifdef SERIAL_ADDER_SUB_EN
    se = s;
`else
    se = 1'b0;
`endif
    mask = (32'd1 << w) - 32'd1;
    xx   = {16'h0, x} & mask;
    yy   = se ? (~{16'h0, y} & mask) : ({16'h0, y} & mask);
    full = xx + yy + (se ? 32'd1 : {31'd0, c});
    sm   = 16'(full & mask);
    co   = full[w];
    ov   = (xx[w-1] == yy[w-1]) && (sm[w-1] != xx[w-1]);
  endfunction

  logic [15:0] es;
  logic        eco, eov;
  int          lat, nd;

  task automatic go0(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s,
                     input string tag);
    logic [15:0] m_s;
    logic        m_c, m_o;
    int          l, n;
    model(8, {8'h0, x}, {8'h0, y}, c, s, m_s, m_c, m_o);
    a8 = x; b8 = y; cin = c; sub = s; st0 = 1'b1;
    tick();
    st0 = 1'b0; a8 = ~x; b8 = 8'h5A; cin = ~c;
    check({tag, "_busy"}, 32'(busy0), 32'd1);
    l = -1; n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done0) begin
        n++;
        if (l < 0) l = k;
      end
    end
    check({tag, "_lat"}, 32'(l), 32'd4);
    check({tag, "_ndone"}, 32'(n), 32'd1);
    check({tag, "_sum"}, 32'(sum0), 32'(m_s[7:0]));
    check({tag, "_cout"}, 32'(cout0), 32'(m_c));
    check({tag, "_ovf"}, 32'(ovf0), 32'(m_o));
  endtask

  initial begin
    logic [7:0]  rx, ry;
    logic [15:0] rx16, ry16;
    logic        rc, rs;
    int          l0, l1, l2, n0, n1, n2;

    st0 = 0; st1 = 0; st2 = 0; a8 = 0; b8 = 0; a16 = 0; b16 = 0; cin = 0; sub = 0;
    #1;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_sum", 32'(sum0), 32'd0);
    check("rst_cout", 32'(cout0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    go0(8'hFF, 8'h01, 1'b0, 1'b0, "t1_ff01");
    check("t1_sum_lit", 32'(sum0), 32'h00);
    check("t1_cout_lit", 32'(cout0), 32'd1);
    go0(8'h7F, 8'h01, 1'b0, 1'b0, "t2_7f01");
    check("t2_ovf_lit", 32'(ovf0), 32'd1);
    go0(8'h80, 8'h80, 1'b0, 1'b0, "t2_8080");
    go0(8'h3C, 8'h41, 1'b1, 1'b0, "t2_cin");
    go0(8'h05, 8'h07, 1'b0, 1'b1, "t3_sub57");
    go0(8'h80, 8'h01, 1'b0, 1'b1, "t3_sub801");

    // Start held into the busy period must be ignored
    a8 = 8'h10; b8 = 8'h20; cin = 0; sub = 0; st0 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'hFF;
    tick();
    st0 = 1'b0;
    lat = -1; nd = 0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (done0) begin
        nd++;
        if (lat < 0) lat = k;
      end
    end
    check("t4_ign_lat", 32'(lat), 32'd4);
    check("t4_ign_ndone", 32'(nd), 32'd1);
    check("t4_ign_sum", 32'(sum0), 32'h30);

    // Start asserted in the done cycle is accepted
    a8 = 8'h10; b8 = 8'h20; st0 = 1'b1;
    tick();
    st0 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      tick();
      if (done0) begin
        lat = k;
        a8 = 8'h03; b8 = 8'h04; st0 = 1'b1;
      end
    end
    check("t4_first_lat", 32'(lat), 32'd4);
    check("t4_first_sum", 32'(sum0), 32'h30);
    tick();
    st0 = 1'b0;
    check("t4_b2b_busy", 32'(busy0), 32'd1);
    check("t4_b2b_done", 32'(done0), 32'd0);
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      tick();
      if (done0) lat = k;
    end
    check("t4_b2b_lat", 32'(lat), 32'd4);
    check("t4_b2b_sum", 32'(sum0), 32'h07);

    // Reset two digits into an operation
    a8 = 8'h55; b8 = 8'h66; st0 = 1'b1;
    tick();
    st0 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy0), 32'd0);
    check("t5_done", 32'(done0), 32'd0);
    check("t5_sum", 32'(sum0), 32'd0);
    check("t5_cout", 32'(cout0), 32'd0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done0) nd++;
    end
    check("t5_no_done", 32'(nd), 32'd0);
    go0(8'hA7, 8'h3B, 1'b1, 1'b0, "t5_after");

    // Random vectors on all three configurations in parallel
    for (int it = 0; it < 1000; it++) begin
      rx = 8'($urandom); ry = 8'($urandom);
      rx16 = 16'($urandom); ry16 = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      a8 = rx; b8 = ry; a16 = rx16; b16 = ry16; cin = rc; sub = rs;
      st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
      tick();
      st0 = 0; st1 = 0; st2 = 0;
      a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      l0 = -1; l1 = -1; l2 = -1; n0 = 0; n1 = 0; n2 = 0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (done0) begin n0++; if (l0 < 0) l0 = k; end
        if (done1) begin n1++; if (l1 < 0) l1 = k; end
        if (done2) begin n2++; if (l2 < 0) l2 = k; end
      end
      check("r_lat_8x2", 32'(l0), 32'd4);
      check("r_nd_8x2", 32'(n0), 32'd1);
      check("r_lat_8x1", 32'(l1), 32'd8);
      check("r_nd_8x1", 32'(n1), 32'd1);
      check("r_lat_16x4", 32'(l2), 32'd4);
      check("r_nd_16x4", 32'(n2), 32'd1);
      model(8, {8'h0, rx}, {8'h0, ry}, rc, rs, es, eco, eov);
      check("r_sum_8x2", 32'(sum0), 32'(es[7:0]));
      check("r_cout_8x2", 32'(cout0), 32'(eco));
      check("r_ovf_8x2", 32'(ovf0), 32'(eov));
      check("r_sum_8x1", 32'(sum1), 32'(es[7:0]));
      check("r_cout_8x1", 32'(cout1), 32'(eco));
      check("r_ovf_8x1", 32'(ovf1), 32'(eov));
      model(16, rx16, ry16, rc, rs, es, eco, eov);
      check("r_sum_16x4", 32'(sum2), 32'(es));
      check("r_cout_16x4", 32'(cout2), 32'(eco));
      check("r_ovf_16x4", 32'(ovf2), 32'(eov));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
